pow2_quant: RTL

POW2_QUANT -- requirements
Module: pow2_quant

---
 rtl/pow2_quant_pkg.sv | 6 +
 rtl/pow2_quant_abs_sat.sv | 12 +
 rtl/pow2_quant.sv | 65 ++++++
 3 files changed

// File: rtl/pow2_quant_pkg.sv
// pow2_quant_pkg: shared widths and state encoding for the power-of-two quantizer
package pow2_quant_pkg;
  localparam int DW = 10;
  localparam int SW = 3;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/pow2_quant_abs_sat.sv
// abs_sat: two's-complement magnitude clipped to DW-1 bits
module abs_sat #(
  parameter int DW = pow2_quant_pkg::DW
) (
  input  logic [DW-1:0] d,
  output logic [DW-2:0] m
);
  logic [DW-1:0] n;
  assign n = ~d + 1'b1;
  // only the most negative input still has its top bit set after negation
  assign m = !d[DW-1] ? d[DW-2:0] : n[DW-1] ? '1 : n[DW-2:0];
endmodule

// File: rtl/pow2_quant.sv
// pow2_quant: finds the right-shift code that normalizes |d| to its leading one
module pow2_quant import pow2_quant_pkg::*; #(
  parameter int DW = pow2_quant_pkg::DW,
  parameter int SW = pow2_quant_pkg::SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] s,
  output logic          x,
  output logic          sgn
);
  localparam logic [SW-1:0] SMAX = '1;
  state_t st;
  logic [DW-2:0] m, a;
  logic [SW-1:0] cnt;
  abs_sat #(.DW(DW)) u_abs (.d(d), .m(a));
  // out_valid trails entry into DONE by one cycle, keeping every output registered
  always_ff @(posedge clk)
    if (rst) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      x         <= 1'b0;
      sgn       <= 1'b0;
      cnt       <= '0;
      m         <= '0;
    end else
      case (st)
        IDLE:
          if (in_valid) begin
            in_ready <= 1'b0;
            sgn      <= d[DW-1];
            m        <= a;
            cnt      <= '0;
            x        <= |a;
            if (a == '0) begin
              st <= DONE;
              s  <= SMAX;
            end else
              st <= SCAN;
          end
        SCAN:
          if (m[DW-2] || cnt == SMAX) begin
            st <= DONE;
            s  <= cnt;
          end else begin
            m   <= m << 1;
            cnt <= cnt + 1'b1;
          end
        DONE:
          if (out_valid && out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else
            out_valid <= 1'b1;
        default: st <= IDLE;
      endcase
endmodule
